// File: rtl/demux2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux2_stream
//  Description : 1-to-2 stream demultiplexer with a 2-entry FIFO and a
//                delivered-word counter on each output channel.
//  Revision    : 1.0  initial release
// ============================================================================
module demux2_stream #(
    parameter int W    = 4,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_data,
    input  logic            in_sel,
    output logic            x_valid,
    input  logic            x_ready,
    output logic [W-1:0]    x_data,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [W-1:0]    y_data,
    output logic [CNTW-1:0] x_count,
    output logic [CNTW-1:0] y_count
);

    localparam int         c_NCH       = 2;
    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [c_NCH-1:0] w_out_ready;
    logic [c_NCH-1:0] w_valid;
    logic [c_NCH-1:0] w_full;
    logic             w_in_xfer;
    logic [W-1:0]     w_head  [c_NCH];
    logic [CNTW-1:0]  w_count [c_NCH];

    assign w_out_ready = {y_ready, x_ready};

    // Ready looks only at the addressed channel's fullness, never at the
    // consumer ready, so a stalled channel blocks only words sent to it.
    assign in_ready  = in_sel ? ~w_full[1] : ~w_full[0];
    assign w_in_xfer = in_valid & in_ready;

    generate
        for (genvar ch = 0; ch < c_NCH; ch++) begin : g_chan
            logic [W-1:0]    r_mem [2];
            logic            r_wptr;
            logic            r_rptr;
            logic [1:0]      r_occ;
            logic [CNTW-1:0] r_count;
            logic            w_wr;
            logic            w_rd;

            assign w_valid[ch] = (r_occ != c_OCC_EMPTY);
            assign w_full[ch]  = (r_occ == c_OCC_FULL);
            assign w_wr        = w_in_xfer & (in_sel == 1'(ch));
            assign w_rd        = w_valid[ch] & w_out_ready[ch];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wptr   <= 1'b0;
                    r_rptr   <= 1'b0;
                    r_occ    <= c_OCC_EMPTY;
                    r_count  <= '0;
                end else begin
                    if (w_wr) begin
                        r_mem[r_wptr] <= in_data;
                        r_wptr        <= ~r_wptr;
                    end
                    if (w_rd) begin
                        r_rptr  <= ~r_rptr;
                        r_count <= r_count + 1'b1;
                    end
                    case ({w_wr, w_rd})
                        2'b10:   r_occ <= r_occ + 2'd1;
                        2'b01:   r_occ <= r_occ - 2'd1;
                        default: r_occ <= r_occ;
                    endcase
                end
            end

            // Head comes straight from storage, so outputs stay registered.
            assign w_head[ch]  = r_mem[r_rptr];
            assign w_count[ch] = r_count;
        end
    endgenerate

    assign x_valid = w_valid[0];
    assign y_valid = w_valid[1];
    assign x_data  = w_head[0];
    assign y_data  = w_head[1];
    assign x_count = w_count[0];
    assign y_count = w_count[1];

endmodule
`default_nettype wire

// File: tb/tb_demux2_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux2_stream
//  Description : Directed self-checking bench for demux2_stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux2_stream;

    localparam int W    = 4;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_sel;
    logic            x_valid;
    logic            x_ready;
    logic [W-1:0]    x_data;
    logic            y_valid;
    logic            y_ready;
    logic [W-1:0]    y_data;
    logic [CNTW-1:0] x_count;
    logic [CNTW-1:0] y_count;

    int n_cmp = 0;
    int n_err = 0;

    demux2_stream #(.W(W), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .x_data   (x_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_data   (y_data),
        .x_count  (x_count),
        .y_count  (y_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst      = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic s);
        in_valid = 1'b1;
        in_data  = d;
        in_sel   = s;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        x_ready = 1'b0; y_ready = 1'b0;

        // 1: reset and basic steer
        tick(); tick();
        rst = 1'b0;
        check("rst_xvalid", x_valid, 0);
        check("rst_yvalid", y_valid, 0);
        check("rst_xdata",  x_data, 0);
        check("rst_ydata",  y_data, 0);
        check("rst_ready",  in_ready, 1);
        check("rst_xcount", x_count, 0);
        check("rst_ycount", y_count, 0);
        x_ready = 1'b1; y_ready = 1'b1;
        send(4'h2, 1'b0);
        tick();
        check("t1_xvalid", x_valid, 1);
        check("t1_xdata",  x_data, 4'h2);
        check("t1_yvalid0", y_valid, 0);
        send(4'hB, 1'b1);
        tick();
        check("t1_yvalid", y_valid, 1);
        check("t1_ydata",  y_data, 4'hB);
        check("t1_xdrain", x_valid, 0);
        check("t1_xcount", x_count, 1);
        in_valid = 1'b0;
        tick();
        check("t1_ycount", y_count, 1);
        check("t1_xcount2", x_count, 1);

        // 2: back-pressure isolation
        y_ready = 1'b0; x_ready = 1'b1;
        send(4'h1, 1'b1); #1;
        check("t2_rdy1", in_ready, 1);
        tick();
        send(4'h3, 1'b1); #1;
        check("t2_rdy3", in_ready, 1);
        tick();
        send(4'h5, 1'b1); #1;
        check("t2_rdy5_full", in_ready, 0);
        tick();
        check("t2_rdy5_held", in_ready, 0);
        check("t2_yhead1", y_data, 4'h1);
        check("t2_ycnt_hold", y_count, 1);
        y_ready = 1'b1; #1;
        check("t2_no_passthru", in_ready, 0);
        tick();
        check("t2_yhead3", y_data, 4'h3);
        check("t2_ycnt2", y_count, 2);
        check("t2_rdy5_open", in_ready, 1);
        tick();
        check("t2_yhead5", y_data, 4'h5);
        check("t2_ycnt3", y_count, 3);
        send(4'h7, 1'b0);
        tick();
        check("t2_xvalid7", x_valid, 1);
        check("t2_xdata7", x_data, 4'h7);
        check("t2_ycnt4", y_count, 4);
        check("t2_yempty", y_valid, 0);
        in_valid = 1'b0;
        tick();
        check("t2_xcount", x_count, 2);

        // 3: full throughput with alternating steering
        do_reset();
        x_ready = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(W'(i), i[0]); #1;
            check("t3_ready", in_ready, 1);
            tick();
            if (i[0]) begin
                check("t3_yvalid", y_valid, 1);
                check("t3_ydata", y_data, i);
            end else begin
                check("t3_xvalid", x_valid, 1);
                check("t3_xdata", x_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t3_xcount", x_count, 8);
        check("t3_ycount", y_count, 8);

        // 4: simultaneous read and write at occupancy 1
        do_reset();
        x_ready = 1'b0;
        send(4'h9, 1'b0);
        tick();
        check("t4_head9", x_data, 4'h9);
        send(4'hA, 1'b0);
        x_ready = 1'b1;
        tick();
        check("t4_headA", x_data, 4'hA);
        check("t4_valid", x_valid, 1);
        check("t4_xcount1", x_count, 1);
        in_valid = 1'b0; in_sel = 1'b0; #1;
        check("t4_notfull", in_ready, 1);
        tick();
        check("t4_drained", x_valid, 0);
        check("t4_xcount2", x_count, 2);

        // 5: counter wrap
        do_reset();
        x_ready = 1'b1; y_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send(W'(i), 1'b0);
            tick();
        end
        check("t5_cnt255", x_count, 255);
        check("t5_head", x_data, 4'hF);
        in_valid = 1'b0;
        tick();
        check("t5_cnt_wrap", x_count, 0);
        check("t5_ycount", y_count, 0);

        // 6: reset while both FIFOs are full
        do_reset();
        x_ready = 1'b0; y_ready = 1'b0;
        send(4'h1, 1'b0); tick();
        send(4'h2, 1'b0); tick();
        send(4'h3, 1'b1); tick();
        send(4'h4, 1'b1); tick();
        in_valid = 1'b0; in_sel = 1'b0; #1;
        check("t6_xfull", in_ready, 0);
        in_sel = 1'b1; #1;
        check("t6_yfull", in_ready, 0);
        check("t6_xhead", x_data, 4'h1);
        x_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_xvalid", x_valid, 0);
        check("t6_yvalid", y_valid, 0);
        check("t6_xcount", x_count, 0);
        check("t6_ycount", y_count, 0);
        check("t6_ready_y", in_ready, 1);
        check("t6_xdata", x_data, 0);
        in_sel = 1'b0; #1;
        check("t6_ready_x", in_ready, 1);
        tick();
        check("t6_xcount_after", x_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
